// File: rtl/note_recorder.sv
// Keypad record/playback sequencer: run-length {note, octave, length_ms} buffer.
// Define NOTE_RECORDER_LOOP_EN to make playback wrap to the first entry until play drops.
module note_recorder #(
  parameter int DEPTH = 64,
  parameter int LEN_W = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1ms,
  input  logic [3:0]        key_note,
  input  logic [3:0]        key_octave,
  input  logic              rec,
  input  logic              play,
  output logic [3:0]        note,
  output logic [3:0]        octave,
  output logic              recording,
  output logic              playing,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY} state_t;

  localparam int ENT_W = 8 + LEN_W;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [ADDR_W:0]  CNT_FULL = (ADDR_W+1)'(DEPTH);

  state_t            r_state, w_state_next;
  logic [7:0]        r_cur, w_cur_next;
  logic [LEN_W-1:0]  r_len, w_len_next;
  logic [ADDR_W-1:0] r_ptr, w_ptr_next;
  logic [LEN_W-1:0]  r_elapsed, w_el_next;
  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [ENT_W-1:0]  r_rd;
  logic              r_play_done;
  logic [3:0]        r_note, r_octave;
  logic              r_recording, r_playing, r_full;
  logic [ADDR_W:0]   r_count;

  logic [7:0]        w_key;
  logic [LEN_W-1:0]  w_len_inc, w_el_inc, w_rd_len, w_commit_len;
  logic              w_commit, w_wr_en, w_drop, w_last, w_done_set, w_rec_start;

  assign w_key     = {key_note, key_octave};
  assign w_len_inc = r_len + LEN_W'(tick_1ms);
  assign w_el_inc  = r_elapsed + 1'b1;
  assign w_rd_len  = r_rd[LEN_W-1:0];
  assign w_last    = ((ADDR_W+1)'(r_ptr) + 1'b1) == r_count;
  // Zero-length entries (key changed inside one ms) are never stored.
  assign w_wr_en   = w_commit && (w_commit_len != '0) && (r_count != CNT_FULL);
  assign w_drop    = w_commit && (w_commit_len != '0) && (r_count == CNT_FULL);

  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_commit_len = w_len_inc;
    w_cur_next   = r_cur;
    w_len_next   = r_len;
    w_ptr_next   = r_ptr;
    w_el_next    = r_elapsed;
    w_done_set   = 1'b0;
    w_rec_start  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rec) begin
          w_state_next = S_REC;
          w_rec_start  = 1'b1;
          w_cur_next   = w_key;
          w_len_next   = '0;
        end else if (play && (r_count != '0) && !r_play_done) begin
          w_state_next = S_PLAY;
          w_ptr_next   = '0;
          w_el_next    = '0;
        end
      end
      S_REC: begin
        if (!rec) begin
          w_commit     = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_key != r_cur) begin
          w_commit   = 1'b1;
          w_cur_next = w_key;
          w_len_next = '0;
        end else if (tick_1ms && (w_len_inc == LEN_MAX)) begin
          // Saturated run is split into consecutive entries of the same key.
          w_commit   = 1'b1;
          w_len_next = '0;
        end else begin
          w_len_next = w_len_inc;
        end
      end
      S_PLAY: begin
        if (!play) begin
          w_state_next = S_IDLE;
        end else if (tick_1ms) begin
          if (w_el_inc == w_rd_len) begin
            w_el_next = '0;
            if (w_last) begin
`ifdef NOTE_RECORDER_LOOP_EN
              w_ptr_next = '0;
`else
              w_state_next = S_IDLE;
              w_done_set   = 1'b1;
`endif
            end else begin
              w_ptr_next = r_ptr + 1'b1;
            end
          end else begin
            w_el_next = w_el_inc;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur       <= '0;
      r_len       <= '0;
      r_ptr       <= '0;
      r_elapsed   <= '0;
      r_play_done <= 1'b0;
      r_note      <= '0;
      r_octave    <= '0;
      r_recording <= 1'b0;
      r_playing   <= 1'b0;
      r_full      <= 1'b0;
      r_count     <= '0;
    end else begin
      r_cur     <= w_cur_next;
      r_len     <= w_len_next;
      r_ptr     <= w_ptr_next;
      r_elapsed <= w_el_next;
      if (w_rec_start) begin
        r_count <= '0;
        r_full  <= 1'b0;
      end else if (w_wr_en) begin
        r_count <= r_count + 1'b1;
        r_full  <= (r_count + 1'b1) == CNT_FULL;
      end else if (w_drop) begin
        r_full  <= 1'b1;
      end
      // Holding play after a one-shot pass must not restart it.
      if (!play)           r_play_done <= 1'b0;
      else if (w_done_set) r_play_done <= 1'b1;
      r_recording <= (w_state_next == S_REC);
      r_playing   <= (w_state_next == S_PLAY);
      if (w_state_next == S_REC)
        {r_note, r_octave} <= w_key;
      else if (w_state_next == S_PLAY && r_state == S_PLAY)
        {r_note, r_octave} <= r_rd[ENT_W-1:LEN_W];
      else
        {r_note, r_octave} <= '0;
    end
  end

  // Read address is the next pointer so r_rd lines up with r_ptr.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_count[ADDR_W-1:0]] <= {r_cur, w_commit_len};
    r_rd <= r_mem[w_ptr_next];
  end

  assign note      = r_note;
  assign octave    = r_octave;
  assign recording = r_recording;
  assign playing   = r_playing;
  assign full      = r_full;
  assign count     = r_count;

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder (DEPTH=4, LEN_W=10); recorded entries are
// queued as expectations and popped while playback is observed.
module tb_note_recorder;

  typedef struct packed {
    logic [3:0]  n;
    logic [3:0]  o;
    logic [15:0] len;
  } ent_t;

  logic       clk, rst_n, tick_1ms, rec, play;
  logic [3:0] key_note, key_octave, note, octave;
  logic       recording, playing, full;
  logic [2:0] count;

  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];

  note_recorder #(.DEPTH(4), .LEN_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1ms(tick_1ms),
    .key_note(key_note), .key_octave(key_octave),
    .rec(rec), .play(play),
    .note(note), .octave(octave),
    .recording(recording), .playing(playing),
    .full(full), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1ms = 1'b1; step();
      tick_1ms = 1'b0; step();
    end
  endtask

  task automatic push(input logic [3:0] n, input logic [3:0] o, input int len);
    ent_t e;
    e.n = n; e.o = o; e.len = 16'(len);
    exp_q.push_back(e);
  endtask

  // Plays the whole buffer, popping one expected entry per stored entry.
  task automatic play_check();
    ent_t e, first;
    int   n;
    logic stable;
    n = exp_q.size();
    first = exp_q[0];
    play = 1'b1; step();
    chk("play_start", 32'(playing), 32'd1);
    step();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      chk("pb_note", 32'({note, octave}), 32'({e.n, e.o}));
      stable = 1'b1;
      for (int t = 1; t < int'(e.len); t++) begin
        tick_1ms = 1'b1; step();
        tick_1ms = 1'b0; step();
        if ({note, octave} !== {e.n, e.o}) stable = 1'b0;
      end
      chk("pb_hold", 32'(stable), 32'd1);
      tick_1ms = 1'b1; step();
      if (k == n - 1) begin
`ifdef NOTE_RECORDER_LOOP_EN
        chk("pb_wrap_playing", 32'(playing), 32'd1);
`else
        chk("pb_end_playing", 32'(playing), 32'd0);
        chk("pb_end_note", 32'({note, octave}), 32'd0);
`endif
      end else begin
        chk("pb_latency", 32'({note, octave}), 32'({e.n, e.o}));
      end
      tick_1ms = 1'b0; step();
    end
`ifdef NOTE_RECORDER_LOOP_EN
    chk("pb_second_pass", 32'({note, octave}), 32'({first.n, first.o}));
    play = 1'b0; step();
    chk("pb_stop_note", 32'({note, octave}), 32'd0);
    chk("pb_stop_playing", 32'(playing), 32'd0);
`else
    step();
    chk("pb_no_restart", 32'(playing), 32'd0);
    play = 1'b0; step();
`endif
  endtask

  initial begin
    rst_n = 1'b0; tick_1ms = 1'b0; rec = 1'b0; play = 1'b0;
    key_note = 4'd0; key_octave = 4'd0;
    step(); step();
    rst_n = 1'b1; step();
    chk("rst_note", 32'({note, octave}), 32'd0);
    chk("rst_flags", 32'({recording, playing, full}), 32'd0);
    chk("rst_count", 32'(count), 32'd0);

    // Basic record: (5,4)x300, rest x100, (7,5)x50
    key_note = 4'd5; key_octave = 4'd4; rec = 1'b1; step();
    chk("rec_flag", 32'(recording), 32'd1);
    chk("rec_passthru", 32'({note, octave}), 32'h54);
    pulses(300);
    key_note = 4'd0; key_octave = 4'd0; step(); push(4'd5, 4'd4, 300);
    chk("rec_count1", 32'(count), 32'd1);
    pulses(100);
    key_note = 4'd7; key_octave = 4'd5; step(); push(4'd0, 4'd0, 100);
    chk("rec_count2", 32'(count), 32'd2);
    pulses(50);
    rec = 1'b0; step(); push(4'd7, 4'd5, 50);
    chk("rec_count3", 32'(count), 32'd3);
    chk("rec_exit", 32'({recording, note, octave}), 32'd0);
    play_check();

    // Tick coinciding with a key change, then a one-clock glitch
    key_note = 4'd3; key_octave = 4'd2; rec = 1'b1; step();
    pulses(4);
    tick_1ms = 1'b1; key_note = 4'd4; step(); push(4'd3, 4'd2, 5);
    tick_1ms = 1'b0;
    chk("coincide_count", 32'(count), 32'd1);
    key_note = 4'd3; step();
    chk("glitch_count", 32'(count), 32'd1);
    pulses(7);
    rec = 1'b0; step(); push(4'd3, 4'd2, 7);
    chk("glitch_final", 32'(count), 32'd2);
    play_check();

    // Overflow: six commits into four entries
    key_note = 4'd1; key_octave = 4'd2; rec = 1'b1; step();
    chk("full_entry", 32'({count, full}), 32'd0);
    for (int i = 0; i < 6; i++) begin
      pulses(10);
      key_note = 4'(i + 2); step();
      if (i < 4) push(4'(i + 1), 4'd2, 10);
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_recording", 32'(recording), 32'd1);
    pulses(3);
    rec = 1'b0; step();
    chk("full_exit", 32'({count, full, recording}), 32'({3'd4, 1'b1, 1'b0}));
    play_check();

    // rec and play together from idle: record wins
    key_note = 4'd0; key_octave = 4'd0; rec = 1'b1; play = 1'b1; step();
    chk("recplay_rec", 32'({recording, playing}), 32'b10);
    rec = 1'b0; play = 1'b0; step();
    chk("empty_count", 32'(count), 32'd0);
    play = 1'b1; step();
    chk("empty_noplay", 32'(playing), 32'd0);
    play = 1'b0; step();

    // Saturating length: 2^10+5 ticks -> {1023},{6}
    key_note = 4'd9; key_octave = 4'd3; rec = 1'b1; step();
    tick_1ms = 1'b1;
    repeat (1029) step();
    tick_1ms = 1'b0;
    chk("sat_split", 32'(count), 32'd1);
    rec = 1'b0; step();
    push(4'd9, 4'd3, 1023); push(4'd9, 4'd3, 6);
    chk("sat_count", 32'(count), 32'd2);
    play_check();

    // Reset mid-record aborts without committing
    key_note = 4'd2; key_octave = 4'd1; rec = 1'b1; step();
    pulses(3);
    rst_n = 1'b0; step();
    rst_n = 1'b1; rec = 1'b0; step();
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_flags", 32'({recording, playing, note, octave}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
